sobel_frame_sequencer: RTL and testbench
========================================

// Module: sobel_frame_sequencer
// PURPOSE
//  Frame-level controller for sobel_filter: accepts a raster pixel stream, feeds the filter one pixel per accept, and
//  tracks row/col position. Discards each row's first 2 (window-fill) results, buffers kept magnitudes in a result FIFO,
//  and returns them on a ready/valid stream. Filter has no backpressure, so issue is credit-gated on FIFO space.
// PARAMETERS
//  IMG_W      64  pixels per row (>=3)
//  IMG_H      48  rows per frame (>=1)
//  FILT_LAT   3   cycles from filt_valid to matching filt_magnitude (>=1)
//  RES_DEPTH  4   result FIFO entries (power of 2, >=2)
// PORTS
//  clk             in   1  clock; all logic on posedge
//  reset           in   1  synchronous, active-high reset
//  start           in   1  1-cycle pulse: begin a frame (honoured only in IDLE)
//  busy            out  1  high in RUN or DRAIN
//  done            out  1  1-cycle pulse after last result of frame leaves out_*
//  in_data         in   8  pixel
//  in_valid        in   1  pixel available
//  in_ready        out  1  sequencer accepts pixel this cycle
//  filt_p_data     out  8  to filter p_data (= in_data)
//  filt_valid      out  1  to filter valid (= in_valid & in_ready)
//  filt_magnitude  in   8  from filter magnitude
//  out_data        out  8  kept magnitude
//  out_valid       out  1  FIFO non-empty
//  out_ready       in   1  downstream accepts
//  out_last        out  1  with out_valid: final result of frame
//  perf_stall_cnt  out  32 only when SOBEL_SEQ_PERF_EN defined
// BEHAVIOUR
//  - Reset: state=IDLE, busy=0, done=0, in_ready=0, filt_valid=0, out_valid=0, out_last=0, out_data=0, counters/FIFO/tags
//    cleared. Reset mid-frame abandons frame: no out_valid or done in the cycle after reset deasserts; filter not reset.
//  - FSM: IDLE -start-> RUN; RUN -(accept at row=IMG_H-1,col=IMG_W-1)-> DRAIN; DRAIN -(tag pipe empty & FIFO empty)-> DONE;
//    DONE (done=1, one cycle) -> IDLE. start outside IDLE ignored.
//  - in_ready = (state==RUN) & (fifo_count + kept_in_flight < RES_DEPTH); combinational, no dependence on in_valid.
//  - Accept = in_valid & in_ready; filt_p_data/filt_valid combinational same cycle. col increments per accept, wraps
//    IMG_W-1 -> 0 with row++; row wraps to 0 at frame end.
//  - Tag pipe: FILT_LAT-deep shift reg of {v, keep, last}; keep = (col>=2); last = keep & final pixel of frame.
//    At tag exit with v&keep, filt_magnitude pushed into FIFO that cycle. Filter's own valid_out not used.
//  - Credits: kept_in_flight = count of v&keep tags in pipe; guarantees FIFO never overflows; push never dropped.
//  - FIFO: first-word-fall-through; pop on out_valid & out_ready; push and pop same cycle when full or empty both legal
//    (count unchanged on simultaneous; empty+push -> out_valid next cycle). out_last travels with its entry.
//  - Results per frame = IMG_H*(IMG_W-2); done fires the cycle after the out_last entry is popped (DRAIN->DONE).
//  - Counter widths $clog2(IMG_W), $clog2(IMG_H); fifo_count $clog2(RES_DEPTH)+1.
// CONFIGURATION
//  SOBEL_SEQ_PERF_EN defined: perf_stall_cnt port exists; increments (saturating at 2^32-1) each RUN cycle with
//    in_valid=1 & in_ready=0; cleared by reset and on start accepted in IDLE.
//  Undefined: port and counter absent; all other behaviour identical.
// TESTING  (IMG_W=4, IMG_H=2, FILT_LAT=3, RES_DEPTH=4 unless noted)
//  1 reset, start, stream 8 pixels in_valid=1, out_ready=1 -> exactly 4 out beats, out_last on 4th, done 1 cycle later, busy low after.
//  2 hold out_ready=0 whole frame -> in_ready drops after 4 kept issues in flight/buffered; no FIFO overflow; release -> all 4 in order.
//  3 model filter as delay-3 echo of p_data, pixels 10..17 -> out_data = 12,13,16,17 (cols 2,3 of each row).
//  4 start pulsed in RUN and DRAIN -> ignored; out count still 4; second start after done -> new frame of 4.
//  5 reset asserted after 5 accepts -> next cycle out_valid=0, busy=0, in_ready=0; fresh start yields full correct frame.
//  6 PERF_EN, out_ready=0, in_valid=1 for 10 RUN cycles after credits exhausted -> perf_stall_cnt=10; cleared by next start.

Source files
------------

// File: rtl/sobel_frame_sequencer.sv
// Frame-level sequencer for sobel_filter: raster issue, window-fill discard, credit-gated result FIFO.
// Optional feature macro SOBEL_SEQ_PERF_EN adds perf_stall_cnt (RUN cycles with in_valid held off).
module sobel_frame_sequencer #(
    parameter int IMG_W     = 64,
    parameter int IMG_H     = 48,
    parameter int FILT_LAT  = 3,
    parameter int RES_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  filt_p_data,
    output logic        filt_valid,
    input  logic [7:0]  filt_magnitude,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last
`ifdef SOBEL_SEQ_PERF_EN
    ,
    output logic [31:0] perf_stall_cnt
`endif
);

    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int PTR_W = $clog2(RES_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);
    localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
    localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W:0]   DEPTH_C  = (CNT_W + 1)'(RES_DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t state_r;
    state_t state_nxt_s;

    logic [COL_W-1:0]    col_r;
    logic [ROW_W-1:0]    row_r;
    logic [FILT_LAT-1:0] tag_v_r;
    logic [FILT_LAT-1:0] tag_keep_r;
    logic [FILT_LAT-1:0] tag_last_r;
    logic [CNT_W-1:0]    kept_r;
    logic [CNT_W-1:0]    fifo_count_r;
    logic [PTR_W-1:0]    wr_ptr_r;
    logic [PTR_W-1:0]    rd_ptr_r;
    logic [7:0]          mem_data_r [RES_DEPTH];
    logic [RES_DEPTH-1:0] mem_last_r;

    logic             accept_s;
    logic             keep_s;
    logic             final_pix_s;
    logic             exit_keep_s;
    logic             exit_last_s;
    logic             push_s;
    logic             pop_s;
    logic             start_ok_s;
    logic             pipe_fill_nxt_s;
    logic [CNT_W:0]   credit_sum_s;
    logic [CNT_W-1:0] fifo_count_nxt_s;
    logic [CNT_W-1:0] kept_nxt_s;

    // Issue gating, tag exit decode, FIFO handshakes and next-count arithmetic.
    always_comb begin
        credit_sum_s     = {1'b0, fifo_count_r} + {1'b0, kept_r};
        in_ready         = 1'b0;
        if ((state_r == ST_RUN) && (credit_sum_s < DEPTH_C)) begin
            in_ready = 1'b1;
        end else begin
            in_ready = 1'b0;
        end
        accept_s         = in_valid & in_ready;
        filt_valid       = accept_s;
        filt_p_data      = in_data;
        start_ok_s       = (state_r == ST_IDLE) & start;
        keep_s           = (col_r >= COL_TWO);
        final_pix_s      = (row_r == ROW_LAST) && (col_r == COL_LAST);
        exit_keep_s      = tag_v_r[FILT_LAT-1] & tag_keep_r[FILT_LAT-1];
        exit_last_s      = exit_keep_s & tag_last_r[FILT_LAT-1];
        push_s           = exit_keep_s;
        out_valid        = (fifo_count_r != {CNT_W{1'b0}});
        out_data         = mem_data_r[rd_ptr_r];
        out_last         = out_valid & mem_last_r[rd_ptr_r];
        pop_s            = out_valid & out_ready;
        busy             = (state_r == ST_RUN) || (state_r == ST_DRAIN);
        done             = (state_r == ST_DONE);

        // Pipe occupancy after this edge: whatever shifts in plus the stages that stay inside.
        pipe_fill_nxt_s  = accept_s;
        for (int i = 0; i < FILT_LAT - 1; i++) begin
            pipe_fill_nxt_s = pipe_fill_nxt_s | tag_v_r[i];
        end

        case ({push_s, pop_s})
            2'b10:   fifo_count_nxt_s = fifo_count_r + CNT_ONE;
            2'b01:   fifo_count_nxt_s = fifo_count_r - CNT_ONE;
            default: fifo_count_nxt_s = fifo_count_r;
        endcase

        case ({accept_s & keep_s, exit_keep_s})
            2'b10:   kept_nxt_s = kept_r + CNT_ONE;
            2'b01:   kept_nxt_s = kept_r - CNT_ONE;
            default: kept_nxt_s = kept_r;
        endcase
    end

    // Frame FSM next state; DRAIN ends on the cycle the final entry is popped.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) state_nxt_s = ST_RUN;
                else       state_nxt_s = ST_IDLE;
            end
            ST_RUN: begin
                if (accept_s && final_pix_s) state_nxt_s = ST_DRAIN;
                else                         state_nxt_s = ST_RUN;
            end
            ST_DRAIN: begin
                if (!pipe_fill_nxt_s && (fifo_count_nxt_s == {CNT_W{1'b0}})) state_nxt_s = ST_DONE;
                else                                                          state_nxt_s = ST_DRAIN;
            end
            ST_DONE:  state_nxt_s = ST_IDLE;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Raster position of the next pixel to be accepted.
    always_ff @(posedge clk) begin
        if (reset || start_ok_s) begin
            col_r <= {COL_W{1'b0}};
            row_r <= {ROW_W{1'b0}};
        end else if (accept_s) begin
            if (col_r == COL_LAST) begin
                col_r <= {COL_W{1'b0}};
                if (row_r == ROW_LAST) row_r <= {ROW_W{1'b0}};
                else                   row_r <= row_r + ROW_ONE;
            end else begin
                col_r <= col_r + COL_ONE;
                row_r <= row_r;
            end
        end else begin
            col_r <= col_r;
            row_r <= row_r;
        end
    end

    // Tag pipe mirrors the filter latency so magnitudes are matched without the filter's own valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            tag_v_r    <= {FILT_LAT{1'b0}};
            tag_keep_r <= {FILT_LAT{1'b0}};
            tag_last_r <= {FILT_LAT{1'b0}};
            kept_r     <= {CNT_W{1'b0}};
        end else begin
            tag_v_r[0]    <= accept_s;
            tag_keep_r[0] <= keep_s;
            tag_last_r[0] <= keep_s & final_pix_s;
            for (int i = 1; i < FILT_LAT; i++) begin
                tag_v_r[i]    <= tag_v_r[i-1];
                tag_keep_r[i] <= tag_keep_r[i-1];
                tag_last_r[i] <= tag_last_r[i-1];
            end
            kept_r <= kept_nxt_s;
        end
    end

    // First-word-fall-through result FIFO; credits guarantee a push always has room.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r     <= {PTR_W{1'b0}};
            rd_ptr_r     <= {PTR_W{1'b0}};
            fifo_count_r <= {CNT_W{1'b0}};
            mem_last_r   <= {RES_DEPTH{1'b0}};
            for (int i = 0; i < RES_DEPTH; i++) begin
                mem_data_r[i] <= 8'd0;
            end
        end else begin
            if (push_s) begin
                mem_data_r[wr_ptr_r] <= filt_magnitude;
                mem_last_r[wr_ptr_r] <= exit_last_s;
                wr_ptr_r             <= wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) rd_ptr_r <= rd_ptr_r + PTR_ONE;
            else       rd_ptr_r <= rd_ptr_r;
            fifo_count_r <= fifo_count_nxt_s;
        end
    end

`ifdef SOBEL_SEQ_PERF_EN
    logic [31:0] perf_cnt_r;

    // Saturating count of RUN cycles where a pixel waited on credits.
    always_ff @(posedge clk) begin
        if (reset || start_ok_s) begin
            perf_cnt_r <= 32'd0;
        end else if ((state_r == ST_RUN) && in_valid && !in_ready && (perf_cnt_r != 32'hFFFF_FFFF)) begin
            perf_cnt_r <= perf_cnt_r + 32'd1;
        end else begin
            perf_cnt_r <= perf_cnt_r;
        end
    end

    assign perf_stall_cnt = perf_cnt_r;
`endif

endmodule

// File: tb/tb_sobel_frame_sequencer.sv
// Bench for sobel_frame_sequencer (4x2 frame, latency 3, depth 4) with a delay-3 echo filter model.
module tb_sobel_frame_sequencer;

    localparam int W     = 4;
    localparam int H     = 2;
    localparam int LAT   = 3;
    localparam int DEPTH = 4;
    localparam int NPIX  = W * H;

    localparam int P_IDLE  = 0;
    localparam int P_RUN   = 1;
    localparam int P_DRAIN = 2;
    localparam int P_DONE  = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       busy, done;
    logic [7:0] in_data = 8'd0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] filt_p_data;
    logic       filt_valid;
    logic [7:0] filt_magnitude;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic       out_last;
`ifdef SOBEL_SEQ_PERF_EN
    logic [31:0] perf_stall_cnt;
`endif

    sobel_frame_sequencer #(.IMG_W(W), .IMG_H(H), .FILT_LAT(LAT), .RES_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .filt_p_data(filt_p_data), .filt_valid(filt_valid), .filt_magnitude(filt_magnitude),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
`ifdef SOBEL_SEQ_PERF_EN
        , .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Filter stand-in: magnitude is p_data delayed by three cycles.
    logic [7:0] fd1, fd2, fd3;
    always @(posedge clk) begin
        fd1 <= filt_p_data;
        fd2 <= fd1;
        fd3 <= fd2;
    end
    assign filt_magnitude = fd3;

    typedef struct {
        logic [7:0] d;
        logic       l;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] got_q[$];
    int n_chk = 0;
    int n_pass = 0;
    int k = 0;
    int outstanding = 0;
    int phase = P_IDLE;
    int frame_outs = 0;
    bit acc_flag = 1'b0;

    task automatic chk(input string name, input int got, input int expv);
        n_chk++;
        if (got == expv) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, expv);
    endtask

    // Frame-level model: every accepted pixel at col>=2 must come back in order; done follows the last pop.
    task automatic monitor();
        int   nxt;
        exp_t e;
        acc_flag = 1'b0;
        if (reset) begin
            exp_q.delete();
            k = 0;
            outstanding = 0;
            phase = P_IDLE;
            return;
        end
        nxt = phase;
        chk("busy", busy, int'(phase == P_RUN || phase == P_DRAIN));
        chk("done", done, int'(phase == P_DONE));
        chk("in_ready", in_ready, int'(phase == P_RUN && outstanding < DEPTH));
        if (phase == P_DONE) nxt = P_IDLE;
        if (phase == P_IDLE && start) begin
            nxt = P_RUN;
            frame_outs = 0;
        end
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out_valid", out_valid, 0);
            end else begin
                chk("out_data", out_data, exp_q[0].d);
                chk("out_last", out_last, exp_q[0].l);
                if (out_ready) begin
                    e = exp_q.pop_front();
                    got_q.push_back(out_data);
                    frame_outs++;
                    outstanding--;
                    if (e.l) nxt = P_DONE;
                end
            end
        end
        if (in_valid && in_ready) begin
            acc_flag = 1'b1;
            if (k % W >= 2) begin
                e.d = in_data;
                e.l = (k == NPIX - 1);
                exp_q.push_back(e);
                outstanding++;
            end
            if (k == NPIX - 1) nxt = P_DRAIN;
            k = (k + 1) % NPIX;
        end
        phase = nxt;
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic feed(input int base, input int first, input int last_excl);
        int pc;
        int cyc;
        pc = first;
        cyc = 0;
        in_valid = 1'b1;
        in_data = 8'(base + pc);
        while (pc < last_excl && cyc < 300) begin
            tick();
            cyc++;
            if (acc_flag) begin
                pc++;
                in_data = 8'(base + pc);
            end
        end
        in_valid = 1'b0;
        if (pc < last_excl) chk("feed_timeout", pc, last_excl);
    endtask

    task automatic wait_idle();
        for (int c = 0; c < 300 && phase != P_IDLE; c++) tick();
        if (phase != P_IDLE) chk("wait_idle_timeout", phase, P_IDLE);
    endtask

    task automatic check_frame(input string name, input int base);
        logic [7:0] refv [4];
        refv[0] = 8'(base + 2);
        refv[1] = 8'(base + 3);
        refv[2] = 8'(base + 6);
        refv[3] = 8'(base + 7);
        chk({name, "_count"}, got_q.size(), 4);
        for (int i = 0; i < 4 && i < got_q.size(); i++) chk({name, "_val"}, got_q[i], refv[i]);
    endtask

`ifdef SOBEL_SEQ_PERF_EN
    logic       p_reset = 1'b1;
    logic       p_start = 1'b0;
    logic       p_busy, p_done, p_in_ready, p_filt_valid, p_out_valid, p_out_last;
    logic       p_in_valid = 1'b0;
    logic       p_out_ready = 1'b0;
    logic [7:0] p_filt_p_data, p_out_data;
    logic [31:0] p_perf;

    sobel_frame_sequencer #(.IMG_W(W), .IMG_H(H), .FILT_LAT(LAT), .RES_DEPTH(2)) dut_perf (
        .clk(clk), .reset(p_reset), .start(p_start), .busy(p_busy), .done(p_done),
        .in_data(8'd5), .in_valid(p_in_valid), .in_ready(p_in_ready),
        .filt_p_data(p_filt_p_data), .filt_valid(p_filt_valid), .filt_magnitude(8'd0),
        .out_data(p_out_data), .out_valid(p_out_valid), .out_ready(p_out_ready), .out_last(p_out_last),
        .perf_stall_cnt(p_perf)
    );
`endif

    initial begin
        // Reset state.
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_done", done, 0);
        chk("rst_filt_valid", filt_valid, 0);
        tick();

        // Basic frame with echo filter: pixels 10..17 give 12,13,16,17.
        out_ready = 1'b1;
        got_q.delete();
        do_start();
        feed(10, 0, NPIX);
        wait_idle();
        check_frame("t1", 10);
        chk("t1_frame_outs", frame_outs, 4);
        chk("t1_busy_after", busy, 0);

        // Downstream stalled for the whole frame, then released.
        out_ready = 1'b0;
        got_q.delete();
        do_start();
        feed(30, 0, NPIX);
        for (int i = 0; i < 6; i++) tick();
        chk("t2_fifo_held", out_valid, 1);
        chk("t2_no_early_pop", got_q.size(), 0);
        out_ready = 1'b1;
        wait_idle();
        check_frame("t2", 30);

        // start pulses in RUN and DRAIN are ignored, then a second frame.
        got_q.delete();
        do_start();
        feed(50, 0, 3);
        start = 1'b1;
        tick();
        start = 1'b0;
        feed(50, 3, NPIX);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_idle();
        chk("t4_frame_outs", frame_outs, 4);
        check_frame("t4", 50);
        got_q.delete();
        do_start();
        feed(60, 0, NPIX);
        wait_idle();
        chk("t4_second_outs", frame_outs, 4);
        check_frame("t4b", 60);

        // Reset after five accepts abandons the frame.
        do_start();
        feed(70, 0, 5);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t5_out_valid", out_valid, 0);
        chk("t5_busy", busy, 0);
        chk("t5_in_ready", in_ready, 0);
        chk("t5_done", done, 0);
        tick();
        got_q.delete();
        do_start();
        feed(80, 0, NPIX);
        wait_idle();
        check_frame("t5", 80);

`ifdef SOBEL_SEQ_PERF_EN
        // Depth-2 instance: credits run out after two kept pixels, then ten stall cycles.
        p_reset = 1'b1;
        tick();
        p_reset = 1'b0;
        p_start = 1'b1;
        tick();
        p_start = 1'b0;
        p_in_valid = 1'b1;
        for (int c = 0; c < 50 && p_in_ready; c++) tick();
        chk("t6_credit_block", p_in_ready, 0);
        for (int i = 0; i < 10; i++) tick();
        chk("t6_perf_10", int'(p_perf), 10);
        p_out_ready = 1'b1;
        for (int c = 0; c < 100 && !p_done; c++) tick();
        chk("t6_done_seen", p_done, 1);
        tick();
        p_in_valid = 1'b0;
        p_start = 1'b1;
        tick();
        p_start = 1'b0;
        chk("t6_perf_cleared", int'(p_perf), 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
